// File: rtl/dac_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_sequencer
// Brief    : FIFO-buffered sample feeder that issues one DAC transfer per rate
//            tick. Define DACSEQ_URCNT_EN to add the urcnt underrun counter.
// Revision : 1.0 - initial release
// ============================================================================
module dac_sample_sequencer #(
  parameter int         RATE_DIV = 200,
  parameter int         DEPTH    = 16,
  parameter logic [7:0] CMD      = 8'h30,
  parameter logic [7:0] IDLE_VAL = 8'h80
) (
  input  logic                     seqclk,
  input  logic                     seqrst,
  input  logic                     seqen,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     stclr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     late,
  output logic                     dacdav,
  input  logic                     davdac,
  output logic [7:0]               daccmd,
  output logic [7:0]               dacdata
`ifdef DACSEQ_URCNT_EN
  ,
  output logic [7:0]               urcnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(RATE_DIV);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_REL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            late_q, late_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      mem_q [DEPTH];

  logic tick, load, pop, push, full_w, empty_w;

  assign full_w  = (level_q == LW'(DEPTH));
  assign empty_w = (level_q == '0);
  assign tick    = seqen && (cnt_q == CW'(RATE_DIV - 1));
  assign load    = (state_q == S_LOAD);
  assign pop     = load && !empty_w;
  assign push    = wr_en && (!full_w || pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pend_q) state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;  // guard cycle: a stale ACK is ignored here
      S_WAIT:  if (davdac) state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A tick landing on the LOAD cycle re-arms pending rather than counting as late.
  always_comb begin
    cnt_d  = '0;
    if (seqen) cnt_d = tick ? '0 : cnt_q + 1'b1;
    pend_d = seqen && (tick || (pend_q && !load));
    late_d = (tick && pend_q && !load) || (late_q && !stclr);
    ovf_d  = (wr_en && !push) || (ovf_q && !stclr);
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    data_d = pop ? mem_q[rptr_q] : data_q;
    cmd_d  = load ? CMD : cmd_q;
  end

  always_ff @(posedge seqclk) begin
    if (seqrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      late_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      data_q  <= IDLE_VAL;
      cmd_q   <= CMD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      late_q  <= late_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
    end
  end

  always_ff @(posedge seqclk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

`ifdef DACSEQ_URCNT_EN
  logic [7:0] urcnt_q, urcnt_d;

  // Clear first, then count, so an underrun coincident with stclr is kept.
  always_comb begin
    urcnt_d = stclr ? 8'h00 : urcnt_q;
    if (load && empty_w && (urcnt_d != 8'hFF)) urcnt_d = urcnt_d + 8'h01;
  end

  always_ff @(posedge seqclk) begin
    if (seqrst) urcnt_q <= 8'h00;
    else        urcnt_q <= urcnt_d;
  end

  assign urcnt = urcnt_q;
`endif

  assign full    = full_w;
  assign empty   = empty_w;
  assign level   = level_q;
  assign ovf     = ovf_q;
  assign late    = late_q;
  assign dacdav  = (state_q == S_SEND) || (state_q == S_WAIT);
  assign daccmd  = cmd_q;
  assign dacdata = data_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_sample_sequencer
// Brief    : Scoreboard bench for dac_sample_sequencer with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_sample_sequencer;

  localparam int         RD    = 40;
  localparam int         DP    = 16;
  localparam logic [7:0] CMDV  = 8'h30;
  localparam logic [7:0] IDLEV = 8'h80;

  logic       seqclk = 1'b0;
  logic       seqrst = 1'b1, seqen = 1'b0, wr_en = 1'b0, stclr = 1'b0, davdac = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, ovf, late, dacdav;
  logic [4:0] level;
  logic [7:0] daccmd, dacdata;
`ifdef DACSEQ_URCNT_EN
  logic [7:0] urcnt;
`endif

  dac_sample_sequencer #(.RATE_DIV(RD), .DEPTH(DP), .CMD(CMDV), .IDLE_VAL(IDLEV)) dut (
    .seqclk(seqclk), .seqrst(seqrst), .seqen(seqen), .wr_en(wr_en), .wr_data(wr_data),
    .stclr(stclr), .full(full), .empty(empty), .level(level), .ovf(ovf), .late(late),
    .dacdav(dacdav), .davdac(davdac), .daccmd(daccmd), .dacdata(dacdata)
`ifdef DACSEQ_URCNT_EN
    , .urcnt(urcnt)
`endif
  );

  always #5 seqclk = ~seqclk;

  int edges = 0;
  always @(posedge seqclk) edges <= edges + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, edges);
    end
  endtask

  // Transfer scoreboard: sample and the edge after which dacdav must rise.
  typedef struct { logic [7:0] data; int edge_n; } exp_t;
  exp_t sb[$];

  // Reference model: sample queue, phase of the transfer in progress, flags.
  logic [7:0] mq[$];
  logic [7:0] m_last = IDLEV;
  int m_cnt = 0, m_ph = 0, m_ur = 0;   // phase 0 idle,1 load,2 send,3 wait,4 release
  bit m_pend = 0, m_late = 0, m_ovf = 0;

  // Driver model state
  int  ack_dly = 34, hold = 0, dcnt = 0;
  bit  acked = 0, rand_ack = 0;

  task automatic drive_ack();
    if (dacdav) begin
      if (!acked) begin
        dcnt++;
        if (dcnt >= ack_dly) begin
          davdac = 1'b1;
          acked  = 1'b1;
          if (rand_ack) ack_dly = $urandom_range(100, 20);
        end
      end
    end else if (acked) begin
      if (hold > 0) hold--;
      else begin
        davdac = 1'b0;
        acked  = 1'b0;
        dcnt   = 0;
        hold   = $urandom_range(2, 0);
      end
    end else begin
      dcnt = 0;
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit we,
                            input logic [7:0] wd, input bit clr, input bit ack);
    bit tick, ld, pp, fl, acc, ur;
    int urn;
    if (rst) begin
      mq.delete(); sb.delete();
      m_last = IDLEV; m_cnt = 0; m_ph = 0; m_ur = 0;
      m_pend = 0; m_late = 0; m_ovf = 0;
      return;
    end
    tick = en && (m_cnt == RD - 1);
    ld   = (m_ph == 1);
    pp   = ld && (mq.size() > 0);
    ur   = ld && !pp;
    fl   = (mq.size() == DP);
    if (ld) begin
      if (pp) m_last = mq.pop_front();
      sb.push_back('{m_last, edges + 1});
    end
    acc    = we && (!fl || pp);
    m_ovf  = (we && !acc) || (m_ovf && !clr);
    m_late = (tick && m_pend && !ld) || (m_late && !clr);
    urn    = clr ? 0 : m_ur;
    if (ur && urn < 255) urn++;
    m_ur   = urn;
    if (acc) mq.push_back(wd);
    case (m_ph)
      0: if (m_pend) m_ph = 1;
      1: m_ph = 2;
      2: m_ph = 3;
      3: if (ack) m_ph = 4;
      default: m_ph = 0;
    endcase
    m_pend = en && (tick || (m_pend && !ld));
    m_cnt  = en ? ((m_cnt == RD - 1) ? 0 : m_cnt + 1) : 0;
  endtask

  // One clock: drive at negedge, predict, compare after the edge.
  task automatic cyc(input bit rst, input bit en, input bit we,
                     input logic [7:0] wd, input bit clr);
    seqrst = rst; seqen = en; wr_en = we; wr_data = wd; stclr = clr;
    drive_ack();
    model_step(rst, en, we, wd, clr, davdac);
    @(posedge seqclk);
    #1;
    chk("level",  int'(level),  mq.size());
    chk("empty",  int'(empty),  int'(mq.size() == 0));
    chk("full",   int'(full),   int'(mq.size() == DP));
    chk("ovf",    int'(ovf),    int'(m_ovf));
    chk("late",   int'(late),   int'(m_late));
    chk("dacdav", int'(dacdav), int'(m_ph == 2 || m_ph == 3));
    chk("daccmd", int'(daccmd), int'(CMDV));
`ifdef DACSEQ_URCNT_EN
    chk("urcnt",  int'(urcnt),  m_ur);
`endif
    @(negedge seqclk);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(0, en, 0, 8'h00, 0);
  endtask

  initial begin : monitor
    bit prev = 0;
    logic [7:0] held = 8'h00;
    exp_t e;
    forever begin
      @(negedge seqclk);
      if (dacdav && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("xfer_data", int'(dacdata), int'(e.data));
          chk("xfer_edge", edges, e.edge_n);
        end
        held = dacdata;
      end else if (dacdav) begin
        chk("data_stable", int'(dacdata), int'(held));
      end
      prev = dacdav;
    end
  end

  initial begin : stim
    int n;
    @(negedge seqclk);
    // T1: two samples sent one tick apart
    cyc(1, 0, 0, 8'h00, 0); cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h11, 0); cyc(0, 0, 1, 8'h22, 0);
    ack_dly = 34;
    run(130, 1);
    // T2: underruns from reset resend mid-scale
    cyc(1, 0, 0, 8'h00, 0);
    run(130, 1);
    // T3: overfill with ticks stopped, then drain
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 8'(8'hA0 + i), 0);
    cyc(0, 0, 0, 8'h00, 1);
    run(17 * RD + 40, 1);
    // T5: full FIFO, write only on the pop cycle
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < DP; i++) cyc(0, 0, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 3 * RD + 20; i++)
      cyc(0, 1, (m_ph == 1 && mq.size() == DP), 8'(8'hC0 + i), 0);
    // T4: slow driver makes ticks late
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(8'h60 + i), 0);
    ack_dly = 90;
    run(400, 1);
    run(250, 0);
    cyc(0, 0, 0, 8'h00, 1);
    run(5, 0);
    // T6: reset while waiting for the ACK
    ack_dly = 34;
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h5A, 0); cyc(0, 0, 1, 8'h5B, 0);
    n = 0;
    while (m_ph != 3 && n < 200) begin cyc(0, 1, 0, 8'h00, 0); n++; end
    chk("reach_wait", int'(m_ph == 3), 1);
    cyc(0, 1, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    run(100, 1);
    // Randomized traffic with variable driver latency
    cyc(1, 0, 0, 8'h00, 0);
    rand_ack = 1;
    begin
      bit en = 1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(299, 0) == 0) en = !en;
        cyc(0, en, ($urandom_range(2, 0) == 0), 8'($urandom),
            ($urandom_range(49, 0) == 0));
      end
    end
    run(300, 0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
